// File: rtl/ntt_agu_param.sv
// Parametrised radix-2^RADIX_LOG NTT address generator: walks every stage of a
// 2^LOGN transform and emits one group of R butterfly indices per cycle through a valid/ready register.
module ntt_agu_param #(
  parameter int LOGN      = 12,
  parameter int RADIX_LOG = 4,
  localparam int STAGES   = LOGN / RADIX_LOG,
  localparam int SW       = (STAGES > 1) ? $clog2(STAGES) : 1,
  localparam int R        = 1 << RADIX_LOG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              inverse,
  output logic              busy,
  output logic [R*LOGN-1:0] order,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SW-1:0]     out_stage,
  output logic              stage_last,
  output logic              xform_last,
  output logic              done
);

  localparam logic [LOGN-1:0] ONES       = {LOGN{1'b1}};
  localparam logic [LOGN-1:0] DMASK      = ONES >> (LOGN - RADIX_LOG);
  localparam logic [LOGN-1:0] ONE_N      = LOGN'(1);
  localparam logic [SW-1:0]   ONE_S      = SW'(1);
  localparam logic [SW-1:0]   LAST_STAGE = SW'(STAGES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state;
  logic            inv;
  logic [LOGN-1:0] i;
  logic [LOGN-1:0] j;
  logic [SW-1:0]   l;

  int              sh_lo;
  int              sh_hi;
  logic [LOGN-1:0] imax;
  logic [LOGN-1:0] jmax;
  logic [LOGN-1:0] base;
  logic [R*LOGN-1:0] lanes;
  logic [SW-1:0]   last_l;
  logic            end_stage;
  logic            end_xform;
  logic            load;

  // Radix-R digit reversal of the low nd digits of v.
  function automatic logic [LOGN-1:0] digit_rev(input logic [LOGN-1:0] v, input int nd);
    logic [LOGN-1:0] r;
    r = '0;
    for (int d = 0; d < STAGES; d++) begin
      if (d < nd) begin
        r = r | (((v >> (RADIX_LOG * d)) & DMASK) << (RADIX_LOG * (nd - 1 - d)));
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Loop bounds for the current stage and the lane indices of the pending group.
  // The three index terms occupy disjoint bit ranges, so OR stands in for addition.
  always_comb begin
    sh_lo = RADIX_LOG * int'(l);
    sh_hi = sh_lo + RADIX_LOG;
    imax  = ONES >> sh_hi;
    jmax  = ~(ONES << sh_lo);
    base  = (digit_rev(j, int'(l)) << (LOGN - sh_lo)) | i;
    lanes = '0;
    for (int m = 0; m < R; m++) begin
      lanes[m*LOGN +: LOGN] = base | (LOGN'(m) << (LOGN - sh_hi));
    end
    if (inv) begin
      last_l = '0;
    end else begin
      last_l = LAST_STAGE;
    end
    end_stage = (i == imax) && (j == jmax);
    end_xform = end_stage && (l == last_l);
    load      = !out_valid || out_ready;
  end

  // Control FSM, stage/group counters and the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      inv        <= 1'b0;
      i          <= '0;
      j          <= '0;
      l          <= '0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      order      <= '0;
      out_stage  <= '0;
      stage_last <= 1'b0;
      xform_last <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            inv   <= inverse;
            i     <= '0;
            j     <= '0;
            l     <= inverse ? LAST_STAGE : '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (load) begin
            order      <= lanes;
            out_stage  <= l;
            stage_last <= end_stage;
            xform_last <= end_xform;
            out_valid  <= 1'b1;
            if (end_xform) begin
              state <= DRAIN;
            end else if (end_stage) begin
              i <= '0;
              j <= '0;
              l <= inv ? (l - ONE_S) : (l + ONE_S);
            end else if (i == imax) begin
              i <= '0;
              j <= j + ONE_N;
            end else begin
              i <= i + ONE_N;
            end
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_agu_param.sv
// Scoreboard bench for ntt_agu_param: a loop-nest reference model fills per-DUT queues,
// monitors pop and compare on every accepted group; covers backpressure, ignored starts and mid-run reset.
module tb_ntt_agu_param;

  localparam int NA = 8;
  localparam int RA = 2;
  localparam int NB = 12;
  localparam int RB = 4;

  typedef struct {
    logic [191:0] ord;
    int           stg;
    bit           sl;
    bit           xl;
  } grp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst;
  logic a_start, a_inv, a_busy, a_valid, a_ready, a_sl, a_xl, a_done;
  logic [4*NA-1:0] a_order;
  logic [1:0] a_stage;
  logic b_start, b_inv, b_busy, b_valid, b_ready, b_sl, b_xl, b_done;
  logic [16*NB-1:0] b_order;
  logic [1:0] b_stage;

  ntt_agu_param #(.LOGN(NA), .RADIX_LOG(RA)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .inverse(a_inv), .busy(a_busy),
    .order(a_order), .out_valid(a_valid), .out_ready(a_ready), .out_stage(a_stage),
    .stage_last(a_sl), .xform_last(a_xl), .done(a_done));

  ntt_agu_param #(.LOGN(NB), .RADIX_LOG(RB)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .inverse(b_inv), .busy(b_busy),
    .order(b_order), .out_valid(b_valid), .out_ready(b_ready), .out_stage(b_stage),
    .stage_last(b_sl), .xform_last(b_xl), .done(b_done));

  int checks = 0;
  int errors = 0;
  grp_t qa[$];
  grp_t qb[$];
  bit a_mode, b_mode;
  int a_acc, b_acc, a_stalls, b_stalls, a_done_cyc, b_done_cyc;
  bit a_done_seen, b_done_seen;

  // Reference: stage order, then j outer, i inner; index from digit-reversed j.
  task automatic gen(input int logn, input int rl, input bit inv, input bit to_b);
    int st, r, l, ni, nj, rev, t, idx;
    grp_t g;
    st = logn / rl;
    r  = 1 << rl;
    for (int s = 0; s < st; s++) begin
      l  = inv ? (st - 1 - s) : s;
      ni = 1 << (logn - rl * (l + 1));
      nj = 1 << (rl * l);
      for (int jj = 0; jj < nj; jj++) begin
        for (int ii = 0; ii < ni; ii++) begin
          rev = 0;
          t = jj;
          for (int d = 0; d < l; d++) begin
            rev = rev * r + (t % r);
            t = t / r;
          end
          g.ord = '0;
          for (int m = 0; m < r; m++) begin
            idx = rev * (1 << (logn - rl * l)) + m * (1 << (logn - rl * (l + 1))) + ii;
            g.ord = g.ord | (192'(idx) << (m * logn));
          end
          g.stg = l;
          g.sl  = (jj == nj - 1) && (ii == ni - 1);
          g.xl  = g.sl && (s == st - 1);
          if (to_b) qb.push_back(g);
          else qa.push_back(g);
        end
      end
    end
  endtask

  initial begin : mon_a
    grp_t g;
    bit dn_exp, held_v, has;
    logic [4*NA-1:0] h_ord, sx;
    logic [1:0] h_stg;
    logic h_sl, h_xl;
    dn_exp = 1'b0;
    held_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        checks++;
        if ({a_busy, a_valid, a_order, a_stage, a_sl, a_xl, a_done} !== '0) begin
          errors++;
          $display("FAIL reset_outputs: busy=%b valid=%b order=%h stage=%0d sl=%b xl=%b done=%b, required all 0",
                   a_busy, a_valid, a_order, a_stage, a_sl, a_xl, a_done);
        end
        dn_exp = 1'b0;
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          checks++;
          if (a_valid !== 1'b1 || a_order !== h_ord || a_stage !== h_stg || a_sl !== h_sl || a_xl !== h_xl) begin
            errors++;
            $display("FAIL stall_hold_a: valid=%b order=%h stage=%0d, required 1 %h %0d", a_valid, a_order, a_stage, h_ord, h_stg);
          end
        end
        if (a_done || dn_exp) begin
          checks++;
          if (a_done !== dn_exp) begin
            errors++;
            $display("FAIL done_pulse_a: done=%b, required %b (cycle %0d)", a_done, dn_exp, cyc);
          end
          if (a_done) begin
            a_done_seen = 1'b1;
            a_done_cyc = cyc;
          end
        end
        dn_exp = 1'b0;
        held_v = a_valid && !a_ready;
        h_ord = a_order; h_stg = a_stage; h_sl = a_sl; h_xl = a_xl;
        if (held_v) a_stalls++;
        if (a_valid && a_ready) begin
          checks++;
          if (qa.size() == 0) begin
            errors++;
            $display("FAIL extra_group_a: order=%h accepted, required no group", a_order);
          end else begin
            g = qa.pop_front();
            if (a_order !== g.ord[4*NA-1:0] || int'(a_stage) != g.stg || a_sl !== g.sl || a_xl !== g.xl) begin
              errors++;
              $display("FAIL group_a[%0d]: order=%h stage=%0d sl=%b xl=%b, required %h %0d %b %b",
                       a_acc, a_order, a_stage, a_sl, a_xl, g.ord[4*NA-1:0], g.stg, g.sl, g.xl);
            end
            if (g.xl) dn_exp = 1'b1;
          end
          has = 1'b1;
          if (!a_mode && a_acc == 0) sx = {8'd192, 8'd128, 8'd64, 8'd0};
          else if (!a_mode && a_acc == 1) sx = {8'd193, 8'd129, 8'd65, 8'd1};
          else if (!a_mode && a_acc == 64) sx = {8'd48, 8'd32, 8'd16, 8'd0};
          else if (!a_mode && a_acc == 193) sx = {8'd67, 8'd66, 8'd65, 8'd64};
          else if (a_mode && a_acc == 0) sx = {8'd3, 8'd2, 8'd1, 8'd0};
          else if (a_mode && a_acc == 255) sx = {8'd255, 8'd191, 8'd127, 8'd63};
          else has = 1'b0;
          if (has) begin
            checks++;
            if (a_order !== sx) begin
              errors++;
              $display("FAIL spot_a[%0d]: order=%h, required %h", a_acc, a_order, sx);
            end
          end
          a_acc++;
        end
      end
    end
  end

  initial begin : mon_b
    grp_t g;
    bit dn_exp, has;
    logic [16*NB-1:0] sx;
    dn_exp = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        dn_exp = 1'b0;
      end else begin
        if (b_done || dn_exp) begin
          checks++;
          if (b_done !== dn_exp) begin
            errors++;
            $display("FAIL done_pulse_b: done=%b, required %b (cycle %0d)", b_done, dn_exp, cyc);
          end
          if (b_done) begin
            b_done_seen = 1'b1;
            b_done_cyc = cyc;
          end
        end
        dn_exp = 1'b0;
        if (b_valid && !b_ready) b_stalls++;
        if (b_valid && b_ready) begin
          checks++;
          if (qb.size() == 0) begin
            errors++;
            $display("FAIL extra_group_b: order=%h accepted, required no group", b_order);
          end else begin
            g = qb.pop_front();
            if (b_order !== g.ord || int'(b_stage) != g.stg || b_sl !== g.sl || b_xl !== g.xl) begin
              errors++;
              $display("FAIL group_b[%0d]: order=%h stage=%0d sl=%b xl=%b, required %h %0d %b %b",
                       b_acc, b_order, b_stage, b_sl, b_xl, g.ord, g.stg, g.sl, g.xl);
            end
            if (g.xl) dn_exp = 1'b1;
          end
          has = 1'b1;
          sx = '0;
          if (!b_mode && b_acc == 256) begin
            for (int m = 0; m < 16; m++) sx[m*NB +: NB] = 12'(m * 16);
          end else if (!b_mode && b_acc == 513) begin
            for (int m = 0; m < 16; m++) sx[m*NB +: NB] = 12'(256 + m);
          end else has = 1'b0;
          if (has) begin
            checks++;
            if (b_order !== sx) begin
              errors++;
              $display("FAIL spot_b[%0d]: order=%h, required %h", b_acc, b_order, sx);
            end
          end
          b_acc++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_a(input bit inv, input int stall_pct, input bit poke);
    int t0, n;
    gen(NA, RA, inv, 1'b0);
    a_mode = inv; a_acc = 0; a_stalls = 0; a_done_seen = 1'b0;
    a_inv = inv; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    t0 = cyc;
    n = 0;
    while (!a_done_seen && n < 4000) begin
      a_ready = ($urandom_range(99) >= stall_pct);
      a_inv   = 1'($urandom);
      a_start = poke && (n == 40 || n == 150);
      tick();
      n++;
    end
    a_start = 1'b0;
    a_ready = 1'b1;
    checks++;
    if (!a_done_seen) begin
      errors++;
      $display("FAIL timeout_a: no done after %0d cycles, required done", n);
    end else if (a_done_cyc - t0 != 257 + a_stalls) begin
      errors++;
      $display("FAIL done_latency_a: %0d cycles, required %0d (stalls %0d)", a_done_cyc - t0, 257 + a_stalls, a_stalls);
    end
    checks++;
    if (qa.size() != 0) begin
      errors++;
      $display("FAIL missing_groups_a: %0d left, required 0", qa.size());
    end
    qa.delete();
    tick();
  endtask

  task automatic run_b(input bit inv, input int stall_pct);
    int t0, n;
    gen(NB, RB, inv, 1'b1);
    b_mode = inv; b_acc = 0; b_stalls = 0; b_done_seen = 1'b0;
    b_inv = inv; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    t0 = cyc;
    n = 0;
    while (!b_done_seen && n < 6000) begin
      b_ready = ($urandom_range(99) >= stall_pct);
      tick();
      n++;
    end
    b_ready = 1'b1;
    checks++;
    if (!b_done_seen) begin
      errors++;
      $display("FAIL timeout_b: no done after %0d cycles, required done", n);
    end else if (b_done_cyc - t0 != 769 + b_stalls) begin
      errors++;
      $display("FAIL done_latency_b: %0d cycles, required %0d", b_done_cyc - t0, 769 + b_stalls);
    end
    checks++;
    if (qb.size() != 0) begin
      errors++;
      $display("FAIL missing_groups_b: %0d left, required 0", qb.size());
    end
    qb.delete();
    tick();
  endtask

  task automatic reset_mid();
    int n;
    gen(NA, RA, 1'b0, 1'b0);
    a_mode = 1'b0; a_acc = 0; a_stalls = 0; a_done_seen = 1'b0;
    a_inv = 1'b0; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    n = 0;
    while (a_acc < 100 && n < 1000) begin
      a_ready = ($urandom_range(99) >= 30);
      tick();
      n++;
    end
    checks++;
    if (a_acc < 100) begin
      errors++;
      $display("FAIL reach_group_100: accepted %0d, required 100", a_acc);
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    qa.delete();
    a_ready = 1'b1;
    repeat (4) tick();
    checks++;
    if (a_done_seen) begin
      errors++;
      $display("FAIL reset_no_done: done seen=1, required 0");
    end
  endtask

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_inv = 1'b0; a_ready = 1'b1;
    b_start = 1'b0; b_inv = 1'b0; b_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    run_a(1'b0, 0, 1'b0);
    run_a(1'b1, 0, 1'b0);
    run_a(1'b0, 30, 1'b1);
    run_a(1'b1, 30, 1'b1);
    reset_mid();
    run_a(1'b0, 0, 1'b0);
    run_b(1'b0, 0);
    run_b(1'b1, 30);
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ntt_agu_param.md
# ntt_agu_param

Parametrised address generation unit for the radix-2^RADIX_LOG NTT datapath. It replaces the fixed radix-16 AGU with a generic one. On a start pulse it walks every stage of an N = 2^LOGN transform. Each cycle it emits one butterfly group of R = 2^RADIX_LOG memory indices through a valid/ready output register. It sits between the NTT controller (start/mode/done) and the bank-conflict-free memory mapper (consumes the index groups).

## Interface
- LOGN, default 12: log2 of transform length. Must be a multiple of RADIX_LOG.
- RADIX_LOG, default 4: log2 of radix R, which is also the lane count.
- STAGES, default LOGN/RADIX_LOG: derived, not overridable.
- clk  in  1  clock. All logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request. Sampled only in IDLE.
- inverse  in  1  stage-order mode. Latched when start is accepted.
- busy  out  1  high from start acceptance until done.
- order  out  R*LOGN  packed group indices. Lane m occupies bits [m*LOGN +: LOGN].
- out_valid  out  1  order/out_stage/stage_last/xform_last are valid.
- out_ready  in  1  consumer accepts the group when out_valid && out_ready.
- out_stage  out  ceil(log2(STAGES))  stage index l of the current group.
- stage_last  out  1  the group is the final group of its stage.
- xform_last  out  1  the group is the final group of the transform.
- done  out  1  one-cycle pulse after the final group is accepted.

## Operation
- FSM states and transitions:
  - IDLE: start=1 goes to RUN. It latches inverse, clears i and j, and sets l = inverse ? STAGES-1 : 0.
  - RUN: the generator advances when load = (!out_valid || out_ready). After the final group is loaded, go to DRAIN.
  - DRAIN: when the final group is accepted, go to IDLE and pulse done.
- Counters for stage l:
  - i runs 0..2^(LOGN-RADIX_LOG*(l+1))-1 and is the inner loop.
  - j runs 0..2^(RADIX_LOG*l)-1 and is the outer loop.
  - Each stage has 2^(LOGN-RADIX_LOG) groups. Each transform has STAGES times that many.
- Wrap and stage advance:
  - i wraps to 0 and increments j.
  - When i and j are both at their upper bounds, both clear and l steps. l steps +1 in forward mode and -1 in inverse mode.
- Index formula: order lane m = rev_l(j)*2^(LOGN-RADIX_LOG*l) + m*2^(LOGN-RADIX_LOG*(l+1)) + i.
  - rev_l is radix-R digit reversal over l digits of RADIX_LOG bits. rev_0(j) = 0.
- Arithmetic:
  - Compute every term with shifts, no multipliers. Width is LOGN bits and the result never overflows.
  - Counter widths are LOGN bits, which covers both i and j.
- Output register:
  - On load, capture all lane indices, l, stage_last and xform_last, and set out_valid.
  - If no new group is loaded and a handshake occurs, out_valid clears.
  - While out_valid && !out_ready, all outputs hold stable.
- Boundary conditions:
  - start while busy is ignored.
  - inverse changes mid-run are ignored.
  - out_ready low in DRAIN holds DRAIN indefinitely.
  - Reset mid-run returns to IDLE immediately with no done pulse.
- Reset values are all 0: busy, out_valid, order, out_stage, stage_last, xform_last, done. The FSM resets to IDLE.

## Timing
- Start is accepted at edge T. busy is high after T.
- The first group is registered at edge T+1. This is a 1-cycle latency from start to out_valid.
- With out_ready held high, throughput is one group per cycle with no bubbles between stages.
  - Group k is valid during the cycle after edge T+1+k.
- The final group G-1 is loaded at edge T+G. It is accepted at edge T+G+1.
  - done and the fall of busy happen after edge T+G+1. done lasts exactly one cycle.
- out_ready low for n cycles stretches the schedule by exactly n cycles. No group is dropped or duplicated.
- A new start is sampled no earlier than the cycle in which done is high. It is legal in that cycle.

## Test plan
- LOGN=8, RADIX_LOG=2, forward, out_ready=1:
  - Group 0 is {0,64,128,192}. Group 1 is {1,65,129,193}.
  - Group 64 (stage 1, j=0, i=0) is {0,16,32,48}.
  - Stage 3 j=1 is {64,65,66,67}.
  - There are 256 groups total. done pulses at T+257.
- Same configuration, inverse=1:
  - out_stage sequence is 3,2,1,0. The first group is {0,1,2,3} and the last group is {63,127,191,255}.
  - stage_last is asserted every 64th group.
- Backpressure:
  - Drop out_ready randomly for 30% of cycles. Order and flags must hold while stalled.
  - The sequence must equal the golden model. done must be delayed by exactly the number of stall cycles.
- Boundaries:
  - A start pulse mid-run has no effect.
  - Assert rst at group 100. All outputs read 0 during reset. A new start then restarts from group 0 with no done pulse.
- LOGN=12, RADIX_LOG=4:
  - Group 256 is {0,16,...,240}. Stage 2 j=1 is {256..271}.
  - done pulses after 768 accepted groups.
